// File: rtl/ichip_pkg.sv
// Shared ichip definitions: default memory geometry and the run-controller state encoding.
package ichip_pkg;

    localparam int unsigned ICHIP_DATA_W = 16;
    localparam int unsigned ICHIP_ADDR_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDumpRd,
        StDumpOut,
        StDone
    } run_state_e;

endpackage

// File: rtl/ichip_run_timer.sv
// Saturating run-cycle counter plus the timeout compare used by ichip_run_ctrl.
module ichip_run_timer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

    // Expiry fires during the last budgeted cycle so RUN lasts exactly TIMEOUT cycles.
    if (TIMEOUT == 0) begin : g_no_timeout
        assign expire = 1'b0;
    end else begin : g_timeout
        localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
        assign expire = enable && (count_q == LIMIT);
    end

endmodule

// File: rtl/ichip_run_ctrl.sv
// ichip run controller: streams a program into memory, runs the CPU until halt or
// timeout, then streams a fixed data window back out.
module ichip_run_ctrl
    import ichip_pkg::*;
#(
    parameter int unsigned DATA_W    = ICHIP_DATA_W,
    parameter int unsigned ADDR_W    = ICHIP_ADDR_W,
    parameter int unsigned DUMP_BASE = 401,
    parameter int unsigned DUMP_LEN  = 30,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_own,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_run,
    input  logic              cpu_halt,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  run_cycles
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DUMP_LEN - 1);

    run_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] hold_q;
    logic              first_q;
    logic              done_q, done_d;
    logic              timed_out_q, timed_out_d;
    logic              start_ok;
    logic              running;
    logic              expire;
    logic              is_last;
    logic [ADDR_W-1:0] dump_addr;

    assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
    assign running   = (state_q == StRun);
    assign is_last   = (idx_q == LAST_IDX);
    assign dump_addr = BASE_ADDR + idx_q;

    ichip_run_timer #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok),
        .enable(running),
        .count (run_cycles),
        .expire(expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = done_q;
        timed_out_d = timed_out_q;
        ld_ready    = 1'b0;
        mem_own     = 1'b1;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        cpu_run     = 1'b0;
        dump_valid  = 1'b0;
        dump_data   = '0;
        dump_last   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StLoad;
                    done_d      = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            StLoad: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                if (ld_valid && ld_last) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cpu_run = 1'b1;
                mem_own = 1'b0;
                idx_d   = '0;
                // A halt in the expiry cycle is a clean finish, not a timeout.
                if (cpu_halt) begin
                    state_d = StDumpRd;
                end else if (expire) begin
                    state_d     = StDumpRd;
                    timed_out_d = 1'b1;
                end
            end
            StDumpRd: begin
                mem_addr = dump_addr;
                state_d  = StDumpOut;
            end
            StDumpOut: begin
                mem_addr   = dump_addr;
                dump_valid = 1'b1;
                dump_last  = is_last;
                // Read data arrives on entry; afterwards the captured copy is presented.
                dump_data  = first_q ? mem_rdata : hold_q;
                if (dump_ready) begin
                    if (is_last) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = StDumpRd;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            hold_q      <= '0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            first_q     <= (state_q == StDumpRd);
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
            if (first_q) begin
                hold_q <= mem_rdata;
            end
        end
    end

    assign done      = done_q;
    assign timed_out = timed_out_q;

endmodule

// File: doc/ichip_run_ctrl.md
# ichip_run_ctrl

Synthesizable run controller for the ichip CPU family: it streams a program image into unified memory, releases the CPU, waits for halt (or a cycle-budget timeout), then streams a configurable data window back out. It replaces the fixed load/run/dump sequence the bench performs by hand with a parametrised hardware block. It sits between a host-side stream interface and the CPU's memory port. While the CPU runs, it reports the run-cycle count.

## Interface
- DATA_W, 16, memory word width
- ADDR_W, 10, memory address width (1024 words)
- DUMP_BASE, 401, first address of the dump window
- DUMP_LEN, 30, words in the dump window; DUMP_BASE+DUMP_LEN ≤ 2**ADDR_W, DUMP_LEN ≥ 1
- CNT_W, 32, run-cycle counter width
- TIMEOUT, 100000, run-cycle budget; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a session; sampled only in IDLE or DONE
- ld_valid  in  1  load word valid
- ld_ready  out  1  high only in LOAD
- ld_addr  in  ADDR_W  load target address
- ld_data  in  DATA_W  load word
- ld_last  in  1  final load word
- mem_own  out  1  1 = controller drives memory port, 0 = CPU drives it
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_addr
- cpu_run  out  1  CPU enable; CPU holds state when low
- cpu_halt  in  1  CPU halted (state register == 0)
- dump_valid  out  1  dump word valid
- dump_ready  in  1  consumer accepts
- dump_data  out  DATA_W  dump word
- dump_last  out  1  with final dump word
- done  out  1  session complete; held until next start
- timed_out  out  1  session ended by timeout, valid with done
- run_cycles  out  CNT_W  cycles spent in RUN, saturating

## Operation
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_OUT, DONE.
- Reset: IDLE. All outputs 0, except mem_own = 1. run_cycles = 0.
- IDLE/DONE, start = 1 -> LOAD. Entering LOAD clears done, timed_out and run_cycles.
- LOAD: ld_ready = 1; mem_we = ld_valid; mem_addr = ld_addr; mem_wdata = ld_data. A handshake with ld_last = 1 -> RUN. cpu_halt is ignored.
- RUN: cpu_run = 1, mem_own = 0, mem_we = 0. run_cycles increments every RUN cycle and saturates at all-ones.
  - cpu_halt = 1 -> DUMP_RD.
  - Otherwise, if TIMEOUT ≠ 0 and run_cycles == TIMEOUT-1 -> DUMP_RD with timed_out = 1.
  - Halt and timeout in the same cycle: halt wins, timed_out = 0.
- DUMP_RD: mem_addr = DUMP_BASE + index (ADDR_W arithmetic, no wrap by construction) -> DUMP_OUT.
- DUMP_OUT:
  - dump_data is registered from mem_rdata on entry and held stable while dump_valid && !dump_ready.
  - dump_last = (index == DUMP_LEN-1).
  - On handshake: if last -> DONE (done = 1), else index++ -> DUMP_RD.
- start outside IDLE/DONE is ignored.
- rst mid-session aborts immediately to IDLE. No partial dump is completed.

## Timing
- Load: one word per cycle while ld_valid is held. Writes commit on the handshake edge.
- cpu_halt high in cycle k -> cpu_run low in k+1; first dump_valid in k+2.
- Dump throughput: at most one word per 2 cycles. Minimum 2*DUMP_LEN cycles from DUMP_RD entry to DONE.
- done rises the cycle after the last dump handshake.

## Structure
- Shared package `ichip_pkg`: state encoding enum and default DATA_W/ADDR_W constants, shared with the CPU.
- Single module. An optional sub-module `ichip_run_timer` holds the saturating counter and timeout compare.

## Test plan
- Load 30 words to 0..29 with ld_last on word 29; CPU halts after 50 cycles -> run_cycles = 50, timed_out = 0, 30 dump words from 401..430 in order, dump_last on the 30th.
- TIMEOUT = 20, cpu_halt never asserted -> DUMP entered after 20 RUN cycles, timed_out = 1, done = 1 after 30 words.
- Hold dump_ready low 5 cycles on word 3 -> dump_data and dump_valid stable, no word skipped or duplicated.
- cpu_halt and timeout on the same cycle (TIMEOUT = 10, halt at run cycle 9) -> timed_out = 0.
- Assert rst during DUMP_OUT of word 12 -> next cycle state IDLE, all outputs at reset values. A new start runs a full session.
- DUMP_BASE = 1014, DUMP_LEN = 10 -> last address 1023, no wrap. start pulsed during RUN is ignored.
